rank_encoder: RTL and testbench
===============================

RANK_ENCODER -- requirements
Module: rank_encoder

Interface
REQ-001 Parameter IMAGE_SIZE, default 784, is the number of pixels per image.
REQ-002 Parameter PIXEL_MAX_VALUE, default 255, is the highest legal pixel intensity.
REQ-003 Parameter LANES, default 4, is the number of pixels compared per scan cycle (1..IMAGE_SIZE).
REQ-004 Parameter MIN_INTENSITY, default 1, is the lowest intensity emitted; pixels below it are never emitted.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 IMAGE  in  IMAGE_SIZE x PW  unpacked pixel array, PW = $clog2(PIXEL_MAX_VALUE+1).
REQ-008 START  in  1  request to capture IMAGE and begin encoding.
REQ-009 ABORT  in  1  cancel the current encoding.
REQ-010 OUT_VALID  out  1  OUT_INDEX holds a valid rank-ordered pixel index.
REQ-011 OUT_READY  in  1  consumer (AER controller) accepts OUT_INDEX.
REQ-012 OUT_INDEX  out  IW  pixel index, IW = $clog2(IMAGE_SIZE).
REQ-013 EMIT_COUNT  out  $clog2(IMAGE_SIZE+1)  indices accepted in the current or last image.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 IMAGE_ENCODED  out  1  one-cycle pulse when an image finishes.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN, EMIT, DONE.
REQ-017 In IDLE with START=1, the block SHALL register all of IMAGE into an internal buffer, set intensity=PIXEL_MAX_VALUE, group=0 and EMIT_COUNT=0, and enter SCAN next cycle; IMAGE is not sampled again until the next START.
REQ-018 START outside IDLE SHALL be ignored.
REQ-019 Captured pixels greater than PIXEL_MAX_VALUE SHALL saturate to PIXEL_MAX_VALUE.
REQ-020 In SCAN, the block SHALL form a LANES-bit match mask for pixels group*LANES..group*LANES+LANES-1 equal to the current intensity; lanes at index >= IMAGE_SIZE SHALL be masked to 0.
REQ-021 SCAN with a non-zero mask SHALL latch the mask and go to EMIT; with a zero mask it SHALL advance (REQ-023).
REQ-022 In EMIT, OUT_VALID SHALL be 1 and OUT_INDEX SHALL be the lowest set bit of the pending mask plus group*LANES; on OUT_VALID&&OUT_READY that bit clears and EMIT_COUNT increments; OUT_INDEX/OUT_VALID SHALL be stable while OUT_READY=0.
REQ-023 Advance: group increments; after the last group, group=0 and intensity decrements; after the last group at intensity==MIN_INTENSITY, go to DONE; otherwise go to SCAN.
REQ-024 EMIT SHALL advance when the last pending bit is accepted, or go to DONE immediately if EMIT_COUNT reaches IMAGE_SIZE.
REQ-025 Ties SHALL be emitted in ascending index order; higher intensity always precedes lower.
REQ-026 DONE SHALL assert IMAGE_ENCODED for exactly one cycle and return to IDLE; EMIT_COUNT holds until the next START.
REQ-027 ABORT=1 in any state SHALL force IDLE next cycle with OUT_VALID=0 that cycle onward and no IMAGE_ENCODED pulse; ABORT has priority over START and OUT_READY.
REQ-028 Worst-case latency per image, with OUT_READY tied high, SHALL be at most (PIXEL_MAX_VALUE-MIN_INTENSITY+1)*ceil(IMAGE_SIZE/LANES) + 2*IMAGE_SIZE + 2 cycles.

Reset
REQ-029 RST SHALL force IDLE, OUT_VALID=0, OUT_INDEX=0, EMIT_COUNT=0, BUSY=0, IMAGE_ENCODED=0, mask=0; the image buffer need not be reset.
REQ-030 RST mid-encoding SHALL discard the image with no handshake completed in that cycle.

Configuration
REQ-031 With RANK_ENC_INTENSITY_OUT_EN defined, port OUT_INTENSITY (out, PW) SHALL present the intensity of the emitted pixel, qualified by OUT_VALID, reset 0; without it the port is absent and behaviour is otherwise identical.

Structure
REQ-032 Package rank_encoder_pkg SHALL hold the state enum type and width helper functions for IW/PW.
REQ-033 Sub-module rank_lane_picker SHALL implement the combinational LANES-wide lowest-set-bit priority encoder (index + any flag).

Verification (IMAGE_SIZE=5, LANES=2, PIXEL_MAX_VALUE=10, MIN_INTENSITY=1)
REQ-034 IMAGE={3,10,0,10,7}, START, OUT_READY=1 -> OUT_INDEX sequence 1,3,4,0; EMIT_COUNT=4; one IMAGE_ENCODED pulse; index 2 never emitted.
REQ-035 IMAGE={5,5,5,5,5}, OUT_READY toggled every other cycle -> 0,1,2,3,4 each held stable until accepted; DONE directly after fifth acceptance, no further scanning.
REQ-036 IMAGE={0,0,0,0,0} -> no OUT_VALID; IMAGE_ENCODED after 10*3 scan cycles; EMIT_COUNT=0.
REQ-037 IMAGE changed after START, second START while BUSY -> output follows captured image; second START ignored.
REQ-038 ABORT during second EMIT -> IDLE next cycle, OUT_VALID=0, no IMAGE_ENCODED; new START then encodes fully.
REQ-039 RST asserted mid-SCAN -> all outputs at reset values next cycle; BUSY=0.

Source files
------------

// File: rtl/rank_encoder_pkg.sv
// Shared state type and width helpers for the rank-order (intensity-sorted) pixel encoder.
package rank_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pix_width(input int maxValue);
    return (maxValue > 0) ? $clog2(maxValue + 1) : 1;
  endfunction

endpackage

// File: rtl/rank_encoder_if.sv
// Output handshake bundle of the rank encoder; OUT_INTENSITY exists only when
// RANK_ENC_INTENSITY_OUT_EN is defined.
interface rank_encoder_if #(
  parameter int IW = 10
`ifdef RANK_ENC_INTENSITY_OUT_EN
  , parameter int PW = 8
`endif
);

  logic          OUT_VALID;
  logic          OUT_READY;
  logic [IW-1:0] OUT_INDEX;
`ifdef RANK_ENC_INTENSITY_OUT_EN
  logic [PW-1:0] OUT_INTENSITY;
`endif

  modport master (
    output OUT_VALID,
    output OUT_INDEX,
`ifdef RANK_ENC_INTENSITY_OUT_EN
    output OUT_INTENSITY,
`endif
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID,
    input  OUT_INDEX,
`ifdef RANK_ENC_INTENSITY_OUT_EN
    input  OUT_INTENSITY,
`endif
    output OUT_READY
  );

endinterface

// File: rtl/rank_lane_picker.sv
// Combinational lowest-set-bit priority encoder across the scan lanes.
module rank_lane_picker
  import rank_encoder_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int LW    = idx_width(LANES)
) (
  input  logic [LANES-1:0] mask_i,
  output logic [LW-1:0]    lane_o,
  output logic             any_o
);

  // Walk from the top lane down so the lowest set lane is the one that sticks.
  always_comb begin
    lane_o = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (mask_i[l]) lane_o = LW'(l);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/rank_encoder.sv
// Rank-order encoder: emits pixel indices brightest-first, ties in ascending index order.
// Optional OUT_INTENSITY output is enabled by defining RANK_ENC_INTENSITY_OUT_EN.
module rank_encoder
  import rank_encoder_pkg::*;
#(
  parameter  int IMAGE_SIZE      = 784,
  parameter  int PIXEL_MAX_VALUE = 255,
  parameter  int LANES           = 4,
  parameter  int MIN_INTENSITY   = 1,
  localparam int PW              = pix_width(PIXEL_MAX_VALUE),
  localparam int IW              = idx_width(IMAGE_SIZE),
  localparam int CW              = $clog2(IMAGE_SIZE + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [PW-1:0] IMAGE [IMAGE_SIZE],
  input  logic          START,
  input  logic          ABORT,
  output logic [CW-1:0] EMIT_COUNT,
  output logic          BUSY,
  output logic          IMAGE_ENCODED,
  rank_encoder_if.master out_if
);

  localparam int            NUM_GROUPS = (IMAGE_SIZE + LANES - 1) / LANES;
  localparam int            GW         = idx_width(NUM_GROUPS);
  localparam int            LW         = idx_width(LANES);
  localparam logic [PW-1:0] PIX_MAX    = PW'(PIXEL_MAX_VALUE);
  localparam logic [PW-1:0] MIN_INT    = PW'(MIN_INTENSITY);

  state_e           state_q, state_d;
  logic [PW-1:0]    intensity_q, intensity_d;
  logic [GW-1:0]    group_q, group_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    img_q [IMAGE_SIZE];

  logic [LANES-1:0] match;
  logic [LW-1:0]    pickLane;
  logic             pendAny;
  logic             outValid;
  logic             advance;

  rank_lane_picker #(.LANES(LANES)) u_picker (
    .mask_i (mask_q),
    .lane_o (pickLane),
    .any_o  (pendAny)
  );

  // Frame buffer is only written on an accepted START; it carries no reset.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == IDLE && START && !ABORT) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        img_q[i] <= (IMAGE[i] > PIX_MAX) ? PIX_MAX : IMAGE[i];
      end
    end
  end

  always_comb begin
    match = '0;
    for (int l = 0; l < LANES; l++) begin
      if (int'(group_q) * LANES + l < IMAGE_SIZE) begin
        match[l] = (img_q[IW'(int'(group_q) * LANES + l)] == intensity_q);
      end
    end
  end

  // ABORT and RST suppress the handshake in the very cycle they are raised.
  assign outValid = (state_q == EMIT) && pendAny && !ABORT && !RST;

  always_comb begin
    state_d     = state_q;
    intensity_d = intensity_q;
    group_d     = group_q;
    mask_d      = mask_q;
    count_d     = count_q;
    advance     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d     = SCAN;
          intensity_d = PIX_MAX;
          group_d     = '0;
          mask_d      = '0;
          count_d     = '0;
        end
      end
      SCAN: begin
        if (|match) begin
          mask_d  = match;
          state_d = EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      EMIT: begin
        if (outValid && out_if.OUT_READY) begin
          mask_d  = mask_q & ~(LANES'(1) << pickLane);
          count_d = count_q + 1'b1;
          if (count_d == CW'(IMAGE_SIZE)) begin
            state_d = DONE;
            mask_d  = '0;
          end else if (mask_d == '0) begin
            advance = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Step to the next lane group, wrapping to the next lower intensity.
    if (advance) begin
      state_d = SCAN;
      if (group_q == GW'(NUM_GROUPS - 1)) begin
        group_d = '0;
        if (intensity_q == MIN_INT) state_d = DONE;
        else                        intensity_d = intensity_q - 1'b1;
      end else begin
        group_d = group_q + 1'b1;
      end
    end
    if (ABORT) begin
      state_d = IDLE;
      mask_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      intensity_q <= '0;
      group_q     <= '0;
      mask_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      intensity_q <= intensity_d;
      group_q     <= group_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
    end
  end

  assign out_if.OUT_VALID = outValid;
  assign out_if.OUT_INDEX = IW'(int'(group_q) * LANES + int'(pickLane));
`ifdef RANK_ENC_INTENSITY_OUT_EN
  assign out_if.OUT_INTENSITY = intensity_q;
`endif
  assign EMIT_COUNT    = count_q;
  assign BUSY          = (state_q != IDLE);
  assign IMAGE_ENCODED = (state_q == DONE) && !ABORT && !RST;

endmodule

// File: tb/tb_rank_encoder.sv
// Directed self-checking bench for rank_encoder with a 5-pixel, 2-lane, 0..10 intensity setup.
module tb_rank_encoder;

  localparam int ImageSize = 5;
  localparam int Lanes     = 2;
  localparam int PixMax    = 10;
  localparam int MinInt    = 1;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [3:0] image [ImageSize];
  logic [2:0] emitCount;
  logic       busy;
  logic       imageEncoded;

  int checks = 0;
  int errors = 0;
  int emitted[$];
  int expSeq[$];
  int pulses, pulseAt, lastAcc, holdErrs;

  rank_encoder_if #(
    .IW(3)
`ifdef RANK_ENC_INTENSITY_OUT_EN
    , .PW(4)
`endif
  ) outIf ();

  rank_encoder #(
    .IMAGE_SIZE      (ImageSize),
    .PIXEL_MAX_VALUE (PixMax),
    .LANES           (Lanes),
    .MIN_INTENSITY   (MinInt)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .IMAGE         (image),
    .START         (START),
    .ABORT         (ABORT),
    .EMIT_COUNT    (emitCount),
    .BUSY          (busy),
    .IMAGE_ENCODED (imageEncoded),
    .out_if        (outIf)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkSeq(input string tag);
    checkOutput({tag, "_len"}, emitted.size(), expSeq.size());
    foreach (expSeq[i]) begin
      checkOutput($sformatf("%s_idx%0d", tag, i),
                  (i < emitted.size()) ? emitted[i] : -1, expSeq[i]);
    end
  endtask

  task automatic applyStimulus(input int p0, input int p1, input int p2, input int p3, input int p4);
    image = '{4'(p0), 4'(p1), 4'(p2), 4'(p3), 4'(p4)};
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Step 0 is the first cycle after the capturing edge; a second START is
  // issued at restartAt with a different image.
  task automatic runEncode(input int readyMode, input int restartAt, input int maxSteps);
    bit prevValid = 1'b0;
    bit prevReady = 1'b0;
    int prevIdx   = 0;
    int firstEnc  = -1;
    emitted.delete();
    pulses   = 0;
    pulseAt  = -1;
    lastAcc  = -1;
    holdErrs = 0;
    for (int k = 0; k < maxSteps; k++) begin
      if (k == restartAt) begin
        image = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        START = 1'b1;
      end else begin
        START = 1'b0;
      end
      outIf.OUT_READY = (readyMode == 0) ? 1'b1 : ((k % 2) == 1);
      if (prevValid && !prevReady) begin
        if (!(outIf.OUT_VALID && int'(outIf.OUT_INDEX) == prevIdx)) holdErrs++;
      end
      if (outIf.OUT_VALID && outIf.OUT_READY) begin
        emitted.push_back(int'(outIf.OUT_INDEX));
        lastAcc = k;
      end
      if (imageEncoded) begin
        pulses++;
        pulseAt = k;
        if (firstEnc < 0) firstEnc = k;
      end
      prevValid = outIf.OUT_VALID;
      prevReady = outIf.OUT_READY;
      prevIdx   = int'(outIf.OUT_INDEX);
      if (firstEnc >= 0 && k >= firstEnc + 2) break;
      tick();
    end
    START = 1'b0;
    outIf.OUT_READY = 1'b1;
  endtask

  initial begin
    int seen;
    bit aborted;
    int strayValid;
    int strayPulse;

    image = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    outIf.OUT_READY = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
    checkOutput("rstValid", outIf.OUT_VALID, 0);
    checkOutput("rstIndex", outIf.OUT_INDEX, 0);
    checkOutput("rstCount", emitCount, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstEncoded", imageEncoded, 0);

    // Basic ordering with a zero pixel that must never appear
    applyStimulus(3, 10, 0, 10, 7);
    runEncode(0, -1, 400);
    expSeq = '{1, 3, 4, 0};
    checkSeq("order");
    checkOutput("orderCount", emitCount, 4);
    checkOutput("orderPulses", pulses, 1);
    checkOutput("orderBusyAfter", busy, 0);

    // Out-of-range pixel saturates to the top intensity and ties with pixel 1
    applyStimulus(15, 10, 0, 0, 0);
    runEncode(0, -1, 400);
    expSeq = '{0, 1};
    checkSeq("sat");
    checkOutput("satCount", emitCount, 2);

    // Flat image with a stalling consumer
    applyStimulus(5, 5, 5, 5, 5);
    runEncode(1, -1, 400);
    expSeq = '{0, 1, 2, 3, 4};
    checkSeq("flat");
    checkOutput("flatHold", holdErrs, 0);
    checkOutput("flatCount", emitCount, 5);
    checkOutput("flatPulses", pulses, 1);
    checkOutput("flatDoneGap", pulseAt - lastAcc, 1);

    // All-zero image: only the 30 scan cycles, then the done pulse
    applyStimulus(0, 0, 0, 0, 0);
    runEncode(0, -1, 400);
    checkOutput("zeroEmits", emitted.size(), 0);
    checkOutput("zeroPulseAt", pulseAt, 30);
    checkOutput("zeroPulses", pulses, 1);
    checkOutput("zeroCount", emitCount, 0);

    // Image changed and START re-issued while busy
    applyStimulus(1, 2, 3, 4, 5);
    runEncode(0, 2, 400);
    expSeq = '{4, 3, 2, 1, 0};
    checkSeq("restart");
    checkOutput("restartCount", emitCount, 5);
    checkOutput("restartPulses", pulses, 1);

    // ABORT beats START in IDLE
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    checkOutput("abortStartBusy", busy, 0);

    // ABORT on the second emitted index
    applyStimulus(3, 10, 0, 10, 7);
    seen = 0;
    aborted = 1'b0;
    for (int k = 0; k < 100 && !aborted; k++) begin
      if (outIf.OUT_VALID) begin
        seen++;
        if (seen == 2) begin
          checkOutput("abortIdx", outIf.OUT_INDEX, 3);
          ABORT = 1'b1;
          aborted = 1'b1;
        end
      end
      tick();
      ABORT = 1'b0;
    end
    checkOutput("abortReached", aborted, 1);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortValid", outIf.OUT_VALID, 0);
    checkOutput("abortEncoded", imageEncoded, 0);
    checkOutput("abortCount", emitCount, 1);
    strayValid = 0;
    strayPulse = 0;
    for (int k = 0; k < 40; k++) begin
      if (outIf.OUT_VALID) strayValid++;
      if (imageEncoded) strayPulse++;
      tick();
    end
    checkOutput("abortStrayValid", strayValid, 0);
    checkOutput("abortStrayPulse", strayPulse, 0);
    applyStimulus(3, 10, 0, 10, 7);
    runEncode(0, -1, 400);
    expSeq = '{1, 3, 4, 0};
    checkSeq("postAbort");
    checkOutput("postAbortPulses", pulses, 1);

    // Reset in the middle of a scan
    applyStimulus(3, 10, 0, 10, 7);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("midBusy", busy, 1);
    checkOutput("midCount", emitCount, 2);
    RST = 1'b1;
    tick();
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstValid", outIf.OUT_VALID, 0);
    checkOutput("midRstIndex", outIf.OUT_INDEX, 0);
    checkOutput("midRstCount", emitCount, 0);
    checkOutput("midRstEncoded", imageEncoded, 0);
    RST = 1'b0;
    tick();
    checkOutput("midRstStayIdle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
